traffic_phase_ctrl: RTL
=======================

# traffic_phase_ctrl

Parametrised successor of the two-road traffic-light controller. It combines the phase state machine, the phase countdown and the tick prescaler in one block, with configurable phase durations and counter width. It adds a main-green minimum hold, a synchronised side-road sensor, a flashing-yellow night mode and a registered two-digit BCD countdown for the tube driver. It sits between the board clock/reset and the lamp and digit outputs.

## Interface
- TICK_DIV, 50_000_000: clocks per countdown tick (1 s at 50 MHz); ≥1.
- CNT_W, 7: countdown width; every duration below must be ≤ 2^CNT_W.
- MAIN_GREEN, 30: main-road green minimum, in ticks; ≥1.
- MAIN_YELLOW, 3: ticks.
- SIDE_GREEN, 20: ticks.
- SIDE_YELLOW, 3: ticks.
- ALL_RED, 2: all-red clearance, ticks.
- FLASH_HALF, 1: ticks per half-period of the night-mode blink.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- c_sensor_state  in  1  side-road vehicle present; asynchronous input.
- flash_en  in  1  night mode request; synchronous to clk.
- m_light_3bit  out  3  main-road lamps {R,Y,G}.
- c_light_3bit  out  3  side-road lamps {R,Y,G}.
- cnt_tens  out  4  BCD tens of the remaining ticks.
- cnt_ones  out  4  BCD ones of the remaining ticks.
- disp_valid  out  1  digits meaningful; 0 in FLASH.
- state_o  out  3  current state code.
- phase_pulse  out  1  one-cycle pulse on every state entry.

## Operation
- States and codes: M_GREEN=0, M_YELLOW=1, M_CLR=2, C_GREEN=3, C_YELLOW=4, C_CLR=5, FLASH=6.
- Lamps (m/c):
  - M_GREEN 001/100
  - M_YELLOW 010/100
  - M_CLR 100/100
  - C_GREEN 100/001
  - C_YELLOW 100/010
  - C_CLR 100/100
  - FLASH: both 010 when blink=1, both 000 when blink=0.
- Prescaler: counts 0..TICK_DIV-1. tick is asserted in the cycle where the prescaler equals TICK_DIV-1. It is cleared on every state entry.
- Countdown `count` (CNT_W bits):
  - On state entry it loads DUR-1 for that state.
  - It decrements on each tick while nonzero.
  - A tick with count==0 ends the state. The next state and its DUR-1 load on that same edge, so each state lasts exactly DUR ticks.
- Transitions:
  - M_GREEN→M_YELLOW on end-tick only if sens_s=1. Otherwise count holds at 0 and the first tick with sens_s=1 transitions.
  - M_YELLOW→M_CLR(ALL_RED)→C_GREEN→C_YELLOW→C_CLR(ALL_RED)→M_GREEN.
- Sensor: c_sensor_state passes through a 2-flop synchroniser to give sens_s, with 2 cycles of latency. Both flops reset to 0.
- Night mode:
  - flash_en=1 in any non-FLASH state moves to FLASH on the next edge, regardless of tick.
  - On entry, blink=1 and the blink counter loads FLASH_HALF-1.
  - blink toggles on each tick where the blink counter is 0, and the counter then reloads.
  - flash_en=0 while in FLASH moves to C_CLR on the next edge, so the road always returns through all-red to M_GREEN.
- Display:
  - Registered, 1 cycle behind count.
  - Value = min(count+1, 99) converted to BCD.
  - In FLASH, cnt_tens=cnt_ones=0 and disp_valid=0.
- Simultaneous events: flash_en outranks an end-tick. A sensor edge during M_YELLOW or later is ignored until the next M_GREEN.

## Timing
- Reset values:
  - state M_GREEN, count MAIN_GREEN-1, prescaler 0, blink 0.
  - m_light 001, c_light 100.
  - cnt_tens/cnt_ones = BCD(min(MAIN_GREEN,99)), disp_valid 1, phase_pulse 0.
- Reset mid-operation returns everything to those values asynchronously. Reset in FLASH exits to M_GREEN.
- Lamps and state_o are registered and change on the same edge as the state.
- phase_pulse is high in the first cycle of each new state. It is not asserted by reset.

## Test plan
1. TICK_DIV=1, MAIN_GREEN=4, sensor held 1. Required: state 0 for 4 cycles, then states 1,2,3,4,5 for 3,2,20,3,2 cycles; lamps match the table at each state; one phase_pulse per entry.
2. Sensor 0 for 50 cycles, then raised. Required: stay in M_GREEN with count=0 and display 01; enter M_YELLOW 3 cycles after the sensor rises (2 synchroniser + 1 edge).
3. TICK_DIV=4, MAIN_GREEN=30. Required: after reset, digits 3/0; they decrement every 4 clocks to 0/1, with the display 1 cycle behind count.
4. flash_en pulsed high in C_GREEN for 10 cycles, TICK_DIV=1, FLASH_HALF=2. Required: next edge gives state 6 with both lamps toggling 010/000 every 2 cycles and disp_valid=0; after release, C_CLR for 2 cycles, then M_GREEN.
5. flash_en asserted on the same cycle as an end-tick in M_YELLOW. Required: FLASH entered, not M_CLR.
6. rst asserted mid C_YELLOW, asynchronous to clk. Required: outputs take reset values before the next edge, and the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road traffic-light controller with tick prescaler,
// per-phase countdown, main-green minimum hold with a synchronised side-road
// sensor, flashing-yellow night mode and a registered two-digit BCD countdown.
module traffic_phase_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int CNT_W       = 7,
  parameter int MAIN_GREEN  = 30,
  parameter int MAIN_YELLOW = 3,
  parameter int SIDE_GREEN  = 20,
  parameter int SIDE_YELLOW = 3,
  parameter int ALL_RED     = 2,
  parameter int FLASH_HALF  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_sensor_state,
  input  logic       flash_en,
  output logic [2:0] m_light_3bit,
  output logic [2:0] c_light_3bit,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       disp_valid,
  output logic [2:0] state_o,
  output logic       phase_pulse
);

  typedef enum logic [2:0] {
    M_GREEN  = 3'd0,
    M_YELLOW = 3'd1,
    M_CLR    = 3'd2,
    C_GREEN  = 3'd3,
    C_YELLOW = 3'd4,
    C_CLR    = 3'd5,
    FLASH    = 3'd6
  } state_t;

  // A one-clock tick still needs a 1-bit prescaler so the vector is legal.
  localparam int              PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] FLASH_RELOAD = CNT_W'(FLASH_HALF - 1);
  localparam int              RST_DISP     = (MAIN_GREEN > 99) ? 99 : MAIN_GREEN;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             blink_q, blink_d;
  logic             sync_meta_q, sens_s_q;
  logic             phase_pulse_q;
  logic [5:0]       lamps_q;
  logic [3:0]       tens_q, ones_q;
  logic             valid_q;
  logic             tick;
  logic             entering;

  // Countdown load value (duration minus one) for the state being entered.
  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      M_GREEN:  dur_m1 = CNT_W'(MAIN_GREEN - 1);
      M_YELLOW: dur_m1 = CNT_W'(MAIN_YELLOW - 1);
      M_CLR:    dur_m1 = CNT_W'(ALL_RED - 1);
      C_GREEN:  dur_m1 = CNT_W'(SIDE_GREEN - 1);
      C_YELLOW: dur_m1 = CNT_W'(SIDE_YELLOW - 1);
      C_CLR:    dur_m1 = CNT_W'(ALL_RED - 1);
      default:  dur_m1 = '0;
    endcase
  endfunction

  // Lamp decode {main RYG, side RYG}; in FLASH both roads blink yellow together.
  function automatic logic [5:0] lamps(input state_t s, input logic b);
    case (s)
      M_GREEN:  lamps = {3'b001, 3'b100};
      M_YELLOW: lamps = {3'b010, 3'b100};
      C_GREEN:  lamps = {3'b100, 3'b001};
      C_YELLOW: lamps = {3'b100, 3'b010};
      FLASH:    lamps = b ? {3'b010, 3'b010} : 6'b000_000;
      default:  lamps = {3'b100, 3'b100};
    endcase
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  // Two-flop synchroniser for the asynchronous side-road sensor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sens_s_q    <= 1'b0;
    end else begin
      sync_meta_q <= c_sensor_state;
      sens_s_q    <= sync_meta_q;
    end
  end

  // Next-state logic: night mode first, then end-of-phase on a tick with count at zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (state_q == FLASH) begin
      if (!flash_en) begin
        state_d = C_CLR;
      end else if (tick) begin
        if (bcnt_q == '0) begin
          blink_d = ~blink_q;
          bcnt_d  = FLASH_RELOAD;
        end else begin
          bcnt_d = bcnt_q - CNT_W'(1);
        end
      end
    end else if (flash_en) begin
      state_d = FLASH;
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        case (state_q)
          M_GREEN:  if (sens_s_q) state_d = M_YELLOW;
          M_YELLOW: state_d = M_CLR;
          M_CLR:    state_d = C_GREEN;
          C_GREEN:  state_d = C_YELLOW;
          C_YELLOW: state_d = C_CLR;
          default:  state_d = M_GREEN;
        endcase
      end
    end
    entering = (state_d != state_q);
    // Every state entry restarts the tick phase and reloads the countdown.
    if (entering) begin
      presc_d = '0;
      count_d = dur_m1(state_d);
      if (state_d == FLASH) begin
        blink_d = 1'b1;
        bcnt_d  = FLASH_RELOAD;
      end
    end
  end

  // State, counters, entry pulse and lamps all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= M_GREEN;
      count_q       <= CNT_W'(MAIN_GREEN - 1);
      presc_q       <= '0;
      blink_q       <= 1'b0;
      bcnt_q        <= '0;
      phase_pulse_q <= 1'b0;
      lamps_q       <= {3'b001, 3'b100};
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      presc_q       <= presc_d;
      blink_q       <= blink_d;
      bcnt_q        <= bcnt_d;
      phase_pulse_q <= entering;
      lamps_q       <= lamps(state_d, blink_d);
    end
  end

  // Display pipeline: one cycle behind count, shows remaining ticks clipped to 99.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q  <= 4'(RST_DISP / 10);
      ones_q  <= 4'(RST_DISP % 10);
      valid_q <= 1'b1;
    end else if (state_q == FLASH) begin
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      tens_q  <= 4'(((int'(count_q) + 1 > 99) ? 99 : int'(count_q) + 1) / 10);
      ones_q  <= 4'(((int'(count_q) + 1 > 99) ? 99 : int'(count_q) + 1) % 10);
      valid_q <= 1'b1;
    end
  end

  assign state_o      = state_q;
  assign m_light_3bit = lamps_q[5:3];
  assign c_light_3bit = lamps_q[2:0];
  assign cnt_tens     = tens_q;
  assign cnt_ones     = ones_q;
  assign disp_valid   = valid_q;
  assign phase_pulse  = phase_pulse_q;

endmodule
